uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
//  Round-robin scheduler sharing one UART_tx transmitter among NUM_REQ requesters.
//  Each requester posts a multi-byte message; the winner's message is latched and
//  sent byte by byte (MSB first) over the trmt/tx_data/tx_done handshake.
//  The winner then gets a one-cycle ack. Sits between the command/telemetry
//  sources and UART_tx.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  MSG_BYTES  2  bytes per message (1..4); message width W = 8*MSG_BYTES
// PORTS
//  clk       in   1              system clock, all state on posedge
//  rst_n     in   1              asynchronous active-low reset
//  req       in   NUM_REQ        level request per requester; held until its ack
//  req_data  in   NUM_REQ*W      message per requester; slice i = req_data[i*W +: W]
//  ack       out  NUM_REQ        one-cycle pulse: requester's message fully sent
//  trmt      out  1              one-cycle start pulse to UART_tx
//  tx_data   out  8              byte to UART_tx; valid in the trmt cycle, then held
//  tx_done   in   1              UART_tx done level; cleared 1 cycle after trmt
//  busy      out  1              high from grant through ack cycle inclusive
//  grant_id  out  $clog2(NUM_REQ) index of current or last granted requester
// BEHAVIOUR
//  Reset: state=IDLE; ack=0, trmt=0, tx_data=0, busy=0, grant_id=0.
//   Round-robin pointer = NUM_REQ-1, so requester 0 has first priority after reset.
//  FSM states: IDLE, LOAD, SEND, WAIT, ACK.
//   IDLE: if |req, grant the first set bit searching from ptr+1 upward (wrapping).
//     Set grant_id to it, latch its slice into msg_sr, byte_cnt=0, ptr=winner.
//     -> LOAD. Otherwise stay.
//   LOAD: drive tx_data=msg_sr[W-1:W-8]; -> SEND.
//   SEND: trmt=1 for exactly one cycle; -> WAIT.
//   WAIT: tx_done is ignored in the first WAIT cycle (guard for UART_tx clear latency).
//     Afterwards, tx_done=1 means the byte is complete:
//     if byte_cnt==MSG_BYTES-1 -> ACK; else msg_sr<<=8, byte_cnt++ -> LOAD.
//   ACK: ack[grant_id]=1 for one cycle; busy still high; -> IDLE.
//  Timing: grant-to-first-trmt = 2 cycles; ack is 1 cycle after the last tx_done
//   is seen.
//   Back-to-back: a request pending at ack can be granted on the cycle after ack.
//  Data is captured at grant. A later req_data change or req drop does not affect
//   the message; it completes and is acked even if req is already low.
//  A requester whose req is still high in the cycle after its ack is treated as a
//   new request. It only wins after the other pending requesters (fairness).
//  Only one bit of ack is ever set; trmt is never asserted outside SEND.
//  tx_data holds its value between trmt pulses.
//  byte_cnt width = max(1,$clog2(MSG_BYTES)); no wrap occurs for legal MSG_BYTES.
//  Asynchronous reset mid-message aborts the message: no ack, all outputs to reset
//   values. UART_tx, on the same reset, drops its frame.
//  tx_done high while IDLE (the normal UART_tx idle state) is ignored.
// TESTING
//  1. Single: req=4'b0010, data1=16'hA55A -> trmt with tx_data=8'hA5, then 8'h5A;
//     ack=4'b0010 once; serial line matches both frames.
//  2. All req=4'b1111 held after reset -> grants in order 0,1,2,3,0 over successive
//     messages; each ack pulse is exactly one cycle.
//  3. Requester 2 drops req and changes data after grant (16'h1234 -> 16'hFFFF) ->
//     bytes sent are 8'h12, 8'h34; ack[2] still pulses.
//  4. UART_tx model holds tx_done high while IDLE and clears it 1 cycle after trmt
//     -> no early byte advance; exactly MSG_BYTES trmt pulses per grant.
//  5. rst_n low while in WAIT on byte 0 -> ack, trmt, busy, tx_data all 0 at once;
//     after release, req0 is served first.
//  6. MSG_BYTES=1, NUM_REQ=2, alternating requests -> one trmt per ack;
//     grant_id alternates 0,1.

Source files
------------

// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter sharing one UART_tx among NUM_REQ message sources.
// Latency: grant to first trmt is 2 cycles; ack 1 cycle after the last tx_done is seen.
// Backpressure: req is held until ack; the next byte waits for UART_tx's tx_done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req / req_data      per-requester level request and message (slice i = req_data[i*W +: W])
//   ack                 one-cycle pulse on the served requester's bit
//   trmt / tx_data      start pulse and byte (MSB first) to UART_tx
//   tx_done             UART_tx done level
//   busy / grant_id     arbiter occupied (grant..ack inclusive), current/last winner
module uart_tx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MSG_BYTES = 2,
    localparam int W        = 8 * MSG_BYTES,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW      = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        ACK  = 3'd4
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [W-1:0]    msg_sr;
    logic [BCW-1:0]  byte_cnt;
    logic            first_wait;

    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;

    // Search from ptr+1 upward with wrap. Walking the offsets from far to near
    // lets the nearest requesting index overwrite any farther one.
    always_comb begin
        win_id = ptr;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                win_id = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= IDW'(NUM_REQ - 1);
            msg_sr     <= '0;
            byte_cnt   <= '0;
            first_wait <= 1'b0;
            ack        <= '0;
            trmt       <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            // Pulse outputs default low; only one state raises each of them.
            ack  <= '0;
            trmt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= win_id;
                        ptr      <= win_id;
                        msg_sr   <= req_data[int'(win_id)*W +: W];
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // tx_data and trmt are registered together so the byte is
                    // already stable in the trmt cycle and held afterwards.
                    tx_data <= msg_sr[W-1 -: 8];
                    trmt    <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    first_wait <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    // UART_tx drops tx_done one cycle after trmt, so the level
                    // seen in the first WAIT cycle is stale and must be skipped.
                    if (first_wait) begin
                        first_wait <= 1'b0;
                    end else if (tx_done) begin
                        if (byte_cnt == BCW'(MSG_BYTES - 1)) begin
                            ack   <= NUM_REQ'(1) << grant_id;
                            state <= ACK;
                        end else begin
                            msg_sr   <= msg_sr << 8;
                            byte_cnt <= byte_cnt + BCW'(1);
                            state    <= LOAD;
                        end
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for uart_tx_arb (4x2-byte and 2x1-byte instances).
// Latency: n/a (bench).
// Backpressure: behavioural UART_tx model holds tx_done high when idle, clears it
// one cycle after trmt and raises it again after a fixed frame time.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;

    // Instance A: NUM_REQ=4, MSG_BYTES=2
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;

    // Instance B: NUM_REQ=2, MSG_BYTES=1
    logic [1:0]  req1;
    logic [15:0] req_data1;
    logic [1:0]  ack1;
    logic        trmt1;
    logic [7:0]  tx_data1;
    logic        tx_done1;
    logic        busy1;
    logic        grant_id1;

    int errors;
    int checks;

    uart_tx_arb #(.NUM_REQ(4), .MSG_BYTES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arb #(.NUM_REQ(2), .MSG_BYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_data(req_data1), .ack(ack1),
        .trmt(trmt1), .tx_data(tx_data1), .tx_done(tx_done1), .busy(busy1), .grant_id(grant_id1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART_tx models: tx_done falls the cycle after trmt is seen, rises again
    // after a fixed frame time, and idles high.
    logic       trmt_d,  trmt1_d;
    logic [3:0] ucnt,    ucnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trmt_d <= 1'b0; tx_done <= 1'b1; ucnt <= '0;
        end else begin
            trmt_d <= trmt;
            if (trmt_d) begin
                tx_done <= 1'b0; ucnt <= 4'd5;
            end else if (!tx_done) begin
                if (ucnt == 4'd0) tx_done <= 1'b1;
                else              ucnt    <= ucnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trmt1_d <= 1'b0; tx_done1 <= 1'b1; ucnt1 <= '0;
        end else begin
            trmt1_d <= trmt1;
            if (trmt1_d) begin
                tx_done1 <= 1'b0; ucnt1 <= 4'd5;
            end else if (!tx_done1) begin
                if (ucnt1 == 4'd0) tx_done1 <= 1'b1;
                else               ucnt1    <= ucnt1 - 4'd1;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_data = '0; req1 = '0; req_data1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 4'b0 || trmt !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_a: ack=%b trmt=%b tx_data=%h busy=%b grant_id=%0d, required all zero",
                     ack, trmt, tx_data, busy, grant_id);
        end
        checks++;
        if (ack1 !== 2'b0 || trmt1 !== 1'b0 || tx_data1 !== 8'h00 || busy1 !== 1'b0 || grant_id1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: ack=%b trmt=%b tx_data=%h busy=%b grant_id=%0d, required all zero",
                     ack1, trmt1, tx_data1, busy1, grant_id1);
        end
        rst_n = 1'b1;
        // Idle with tx_done high must stay quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (trmt !== 1'b0 || busy !== 1'b0 || ack !== 4'b0) begin
                errors++;
                $display("FAIL idle_quiet: cyc=%0d trmt=%b busy=%b ack=%b, required 0", i, trmt, busy, ack);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b[$];
        int         exp_a[$];
        logic [7:0] eb;
        int         ea;
        int         ntrmt;
        logic       prev_trmt;
        logic [7:0] last_b;
        exp_b.push_back(8'hA5); exp_b.push_back(8'h5A);
        exp_a.push_back(1);
        ntrmt = 0; prev_trmt = 1'b0; last_b = '0;
        @(negedge clk);
        req_data[31:16] = 16'hA55A;
        req = 4'b0010;
        for (int cyc = 0; cyc < 200 && (exp_b.size() != 0 || exp_a.size() != 0); cyc++) begin
            @(negedge clk);
            if (prev_trmt) begin
                checks++;
                if (tx_data !== last_b) begin
                    errors++;
                    $display("FAIL single_hold: tx_data=%h after trmt, required %h", tx_data, last_b);
                end
            end
            if (trmt) begin
                ntrmt++; checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL single_byte: extra byte %h, required none", tx_data);
                end else begin
                    eb = exp_b.pop_front();
                    if (tx_data !== eb) begin
                        errors++; $display("FAIL single_byte: tx_data=%h, required %h", tx_data, eb);
                    end
                end
                last_b = tx_data;
            end
            prev_trmt = trmt;
            if (ack !== 4'b0) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL single_ack: extra ack=%b, required none", ack);
                end else begin
                    ea = exp_a.pop_front();
                    if (ack !== (4'b0001 << ea) || grant_id !== 2'(ea) || ntrmt != 2 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL single_ack: ack=%b grant_id=%0d trmts=%0d busy=%b, required ack=%b id=%0d trmts=2 busy=1",
                                 ack, grant_id, ntrmt, busy, 4'b0001 << ea, ea);
                    end
                    req[ea] = 1'b0;
                end
                ntrmt = 0;
            end
        end
        checks++;
        if (exp_b.size() != 0 || exp_a.size() != 0) begin
            errors++; $display("FAIL single_timeout: bytes left=%0d acks left=%0d, required 0", exp_b.size(), exp_a.size());
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_after: ack=%b busy=%b, required ack=0 busy=0", ack, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b[$];
        int         exp_a[$];
        int         order[5];
        logic [7:0] eb;
        int         ea;
        int         ntrmt;
        logic [3:0] prev_ack;
        logic [15:0] sl;
        order = '{0, 1, 2, 3, 0};
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        req_data = 64'h3377_2266_1155_0044;
        foreach (order[i]) begin
            sl = req_data[order[i]*16 +: 16];
            exp_b.push_back(sl[15:8]); exp_b.push_back(sl[7:0]);
            exp_a.push_back(order[i]);
        end
        ntrmt = 0; prev_ack = '0;
        req = 4'b1111;
        for (int cyc = 0; cyc < 600 && (exp_b.size() != 0 || exp_a.size() != 0); cyc++) begin
            @(negedge clk);
            if (trmt) begin
                ntrmt++; checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL rr_byte: extra byte %h, required none", tx_data);
                end else begin
                    eb = exp_b.pop_front();
                    if (tx_data !== eb) begin
                        errors++; $display("FAIL rr_byte: tx_data=%h, required %h", tx_data, eb);
                    end
                end
            end
            if (ack !== 4'b0) begin
                checks++;
                if (prev_ack !== 4'b0) begin
                    errors++; $display("FAIL rr_pulse: ack=%b two cycles running, required one-cycle pulse", ack);
                end
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL rr_ack: extra ack=%b, required none", ack);
                end else begin
                    ea = exp_a.pop_front();
                    if (ack !== (4'b0001 << ea) || grant_id !== 2'(ea) || ntrmt != 2) begin
                        errors++;
                        $display("FAIL rr_ack: ack=%b grant_id=%0d trmts=%0d, required ack=%b id=%0d trmts=2",
                                 ack, grant_id, ntrmt, 4'b0001 << ea, ea);
                    end
                    if (exp_a.size() == 0) req = 4'b0000;
                end
                ntrmt = 0;
            end
            prev_ack = ack;
        end
        checks++;
        if (exp_b.size() != 0 || exp_a.size() != 0) begin
            errors++; $display("FAIL rr_timeout: bytes left=%0d acks left=%0d, required 0", exp_b.size(), exp_a.size());
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0) begin
            errors++; $display("FAIL rr_pulse_end: ack=%b after last ack, required 0", ack);
        end
    endtask

    task automatic test_data_capture();
        logic [7:0] exp_b[$];
        int         exp_a[$];
        logic [7:0] eb;
        int         ea;
        int         cyc;
        exp_b.push_back(8'h12); exp_b.push_back(8'h34);
        exp_a.push_back(2);
        repeat (2) @(negedge clk);
        req_data[47:32] = 16'h1234;
        req = 4'b0100;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (busy !== 1'b1 && cyc < 20);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL cap_grant: busy=%b, required 1", busy);
        end
        req = 4'b0000;
        req_data[47:32] = 16'hFFFF;
        for (int c = 0; c < 200 && (exp_b.size() != 0 || exp_a.size() != 0); c++) begin
            @(negedge clk);
            if (trmt) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL cap_byte: extra byte %h, required none", tx_data);
                end else begin
                    eb = exp_b.pop_front();
                    if (tx_data !== eb) begin
                        errors++; $display("FAIL cap_byte: tx_data=%h, required %h", tx_data, eb);
                    end
                end
            end
            if (ack !== 4'b0) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL cap_ack: extra ack=%b, required none", ack);
                end else begin
                    ea = exp_a.pop_front();
                    if (ack !== (4'b0001 << ea) || grant_id !== 2'(ea)) begin
                        errors++;
                        $display("FAIL cap_ack: ack=%b grant_id=%0d, required ack=%b id=%0d", ack, grant_id, 4'b0001 << ea, ea);
                    end
                end
            end
        end
        checks++;
        if (exp_b.size() != 0 || exp_a.size() != 0) begin
            errors++; $display("FAIL cap_timeout: bytes left=%0d acks left=%0d, required 0", exp_b.size(), exp_a.size());
        end
    endtask

    // Exact cycle timing against the UART model, which keeps tx_done high while idle.
    task automatic test_done_guard();
        int gap;
        int extra;
        repeat (3) @(negedge clk);
        req_data[63:48] = 16'hC35A;
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || trmt !== 1'b0) begin
            errors++; $display("FAIL guard_load: busy=%b trmt=%b, required busy=1 trmt=0", busy, trmt);
        end
        @(negedge clk);
        checks++;
        if (trmt !== 1'b1 || tx_data !== 8'hC3) begin
            errors++; $display("FAIL guard_first: trmt=%b tx_data=%h, required trmt=1 tx_data=c3", trmt, tx_data);
        end
        gap = 0;
        do begin
            @(negedge clk); gap++;
        end while (trmt !== 1'b1 && gap < 40);
        checks++;
        if (gap != 10 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL guard_gap: trmt gap=%0d tx_data=%h, required gap=10 tx_data=5a", gap, tx_data);
        end
        gap = 0; extra = 0;
        do begin
            @(negedge clk); gap++;
            if (trmt) extra++;
        end while (ack === 4'b0 && gap < 40);
        checks++;
        if (gap != 9 || ack !== 4'b1000 || grant_id !== 2'd3 || extra != 0) begin
            errors++;
            $display("FAIL guard_ack: delay=%0d ack=%b grant_id=%0d extra_trmt=%0d, required 9 1000 3 0", gap, ack, grant_id, extra);
        end
        req = 4'b0000;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (trmt || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL guard_idle: %0d active cycles while idle, required 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp_b[$];
        int         exp_a[$];
        logic [7:0] eb;
        int         ea;
        int         cyc;
        req_data[15:0]  = 16'h8E71;
        req_data[63:48] = 16'h4D2B;
        @(negedge clk);
        req = 4'b1001;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (trmt !== 1'b1 && cyc < 20);
        checks++;
        if (trmt !== 1'b1 || tx_data !== 8'h8E) begin
            errors++; $display("FAIL abort_start: trmt=%b tx_data=%h, required trmt=1 tx_data=8e", trmt, tx_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b0 || trmt !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL abort_reset: ack=%b trmt=%b busy=%b tx_data=%h grant_id=%0d, required all zero",
                     ack, trmt, busy, tx_data, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_b.push_back(8'h8E); exp_b.push_back(8'h71); exp_a.push_back(0);
        exp_b.push_back(8'h4D); exp_b.push_back(8'h2B); exp_a.push_back(3);
        for (int c = 0; c < 300 && (exp_b.size() != 0 || exp_a.size() != 0); c++) begin
            @(negedge clk);
            if (trmt) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL abort_byte: extra byte %h, required none", tx_data);
                end else begin
                    eb = exp_b.pop_front();
                    if (tx_data !== eb) begin
                        errors++; $display("FAIL abort_byte: tx_data=%h, required %h", tx_data, eb);
                    end
                end
            end
            if (ack !== 4'b0) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL abort_ack: extra ack=%b, required none", ack);
                end else begin
                    ea = exp_a.pop_front();
                    if (ack !== (4'b0001 << ea) || grant_id !== 2'(ea)) begin
                        errors++;
                        $display("FAIL abort_ack: ack=%b grant_id=%0d, required ack=%b id=%0d", ack, grant_id, 4'b0001 << ea, ea);
                    end
                    req[ea] = 1'b0;
                end
            end
        end
        checks++;
        if (exp_b.size() != 0 || exp_a.size() != 0) begin
            errors++; $display("FAIL abort_timeout: bytes left=%0d acks left=%0d, required 0", exp_b.size(), exp_a.size());
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] exp_b[$];
        int         exp_a[$];
        logic [7:0] eb;
        int         ea;
        int         ntrmt;
        req_data1 = 16'h9D6B;
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back(i % 2);
            exp_b.push_back((i % 2 == 0) ? 8'h6B : 8'h9D);
        end
        ntrmt = 0;
        @(negedge clk);
        req1 = 2'b11;
        for (int c = 0; c < 300 && (exp_b.size() != 0 || exp_a.size() != 0); c++) begin
            @(negedge clk);
            if (trmt1) begin
                ntrmt++; checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL one_byte: extra byte %h, required none", tx_data1);
                end else begin
                    eb = exp_b.pop_front();
                    if (tx_data1 !== eb) begin
                        errors++; $display("FAIL one_byte: tx_data=%h, required %h", tx_data1, eb);
                    end
                end
            end
            if (ack1 !== 2'b0) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL one_ack: extra ack=%b, required none", ack1);
                end else begin
                    ea = exp_a.pop_front();
                    if (ack1 !== (2'b01 << ea) || grant_id1 !== 1'(ea) || ntrmt != 1) begin
                        errors++;
                        $display("FAIL one_ack: ack=%b grant_id=%0d trmts=%0d, required ack=%b id=%0d trmts=1",
                                 ack1, grant_id1, ntrmt, 2'b01 << ea, ea);
                    end
                    if (exp_a.size() == 0) req1 = 2'b00;
                end
                ntrmt = 0;
            end
        end
        checks++;
        if (exp_b.size() != 0 || exp_a.size() != 0) begin
            errors++; $display("FAIL one_timeout: bytes left=%0d acks left=%0d, required 0", exp_b.size(), exp_a.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_data_capture();
        test_done_guard();
        test_reset_abort();
        test_single_byte();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
